// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory behind a valid/ready request
// channel with a fixed-latency, one-cycle response strobe.
//
// Optional build macro DMEM_RESP_MMIO_EN adds a console register at word
// address 0xFFFF_FFF0 (con_data / con_strobe ports, write counter on read).
// Without it the console address is simply out of range.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | req_ready high, waiting for req_valid
// ST_WAIT   | request captured, down-counting the configured wait cycles
// ST_RESP   | resp_valid high for this single cycle, then back to idle
module data_mem_responder #(
    parameter int MEM_SIZE    = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_RESP_MMIO_EN
    ,
    output logic [7:0]  con_data,
    output logic        con_strobe
`endif
);

    localparam int WORDS = MEM_SIZE / 4;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    // Counter is loaded with WAIT_CYCLES-1 so terminal count 0 ends the wait.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [31:0]   mem [0:WORDS-1];

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   cap_addr;
    logic          cap_we;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_be;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          accept;
    logic          enter_resp;
    logic [31:0]   op_addr;
    logic          op_we;
    logic [31:0]   op_wdata;
    logic [3:0]    op_be;
    logic [AW-1:0] op_idx;
    logic          op_is_con;
    logic          op_err;
    logic [31:0]   rd_word;

`ifdef DMEM_RESP_MMIO_EN
    localparam logic [31:0] CON_ADDR = 32'hFFFF_FFF0;
    logic [31:0]   con_count;
`endif

    assign req_ready  = (state == ST_IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // With no wait cycles the access commits on the accept edge itself, so the
    // operation fields come straight from the inputs while idle.
    always_comb begin
        op_addr    = cap_addr;
        op_we      = cap_we;
        op_wdata   = cap_wdata;
        op_be      = cap_be;
        if (state == ST_IDLE) begin
            op_addr  = req_addr;
            op_we    = req_we;
            op_wdata = req_wdata;
            op_be    = req_be;
        end
        op_idx     = op_addr[AW+1:2];
`ifdef DMEM_RESP_MMIO_EN
        op_is_con  = (op_addr == CON_ADDR);
`else
        op_is_con  = 1'b0;
`endif
        op_err     = (op_addr[1:0] != 2'b00) ||
                     ((op_addr >= 32'(MEM_SIZE)) && !op_is_con);
        enter_resp = ((state == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state == ST_WAIT) && (cnt == 4'd0));
        rd_word    = 32'd0;
        if (!op_err && !op_we) begin
`ifdef DMEM_RESP_MMIO_EN
            rd_word = op_is_con ? con_count : mem[op_idx];
`else
            rd_word = mem[op_idx];
`endif
        end
    end

    // Request FSM, wait down-counter and request capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            cap_addr  <= 32'd0;
            cap_we    <= 1'b0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap_addr  <= req_addr;
                        cap_we    <= req_we;
                        cap_wdata <= req_wdata;
                        cap_be    <= req_be;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Response data/error are loaded on the edge entering RESP and cleared on
    // every other edge, so they read as zero whenever resp_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= rd_word;
            err_q   <= op_err;
        end else begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end
    end

    // Byte-lane memory write on the edge entering RESP; memory is never reset.
    always_ff @(posedge clk) begin
        if (enter_resp && op_we && !op_err && !op_is_con) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be[i]) begin
                    mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_RESP_MMIO_EN
    // Console register: latch the low byte, strobe during RESP, count writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            con_data   <= 8'd0;
            con_strobe <= 1'b0;
            con_count  <= 32'd0;
        end else begin
            con_strobe <= 1'b0;
            if (enter_resp && op_is_con && !op_err && op_we && op_be[0]) begin
                con_data   <= op_wdata[7:0];
                con_strobe <= 1'b1;
                con_count  <= con_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: default instance (WAIT_CYCLES = 1)
// for functional checks, second instance (WAIT_CYCLES = 3) for timing.
// Console checks are compiled in when DMEM_RESP_MMIO_EN is defined.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        req_valid_3;
    logic        req_ready_3;
    logic [31:0] req_addr_3;
    logic        req_we_3;
    logic [31:0] req_wdata_3;
    logic [3:0]  req_be_3;
    logic        resp_valid_3;
    logic [31:0] resp_rdata_3;
    logic        resp_err_3;

    int checks;
    int errors;

`ifdef DMEM_RESP_MMIO_EN
    logic [7:0]  con_data;
    logic        con_strobe;
    logic [7:0]  con_data_3;
    logic        con_strobe_3;
    int          strobe_cnt;
`endif

    data_mem_responder #(.MEM_SIZE(1024), .WAIT_CYCLES(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
`ifdef DMEM_RESP_MMIO_EN
        ,
        .con_data   (con_data),
        .con_strobe (con_strobe)
`endif
    );

    data_mem_responder #(.MEM_SIZE(1024), .WAIT_CYCLES(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid_3),
        .req_ready  (req_ready_3),
        .req_addr   (req_addr_3),
        .req_we     (req_we_3),
        .req_wdata  (req_wdata_3),
        .req_be     (req_be_3),
        .resp_valid (resp_valid_3),
        .resp_rdata (resp_rdata_3),
        .resp_err   (resp_err_3)
`ifdef DMEM_RESP_MMIO_EN
        ,
        .con_data   (con_data_3),
        .con_strobe (con_strobe_3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DMEM_RESP_MMIO_EN
    initial strobe_cnt = 0;
    always @(negedge clk) if (con_strobe) strobe_cnt++;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the cycle after RESP.
    task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd,
                          output logic er, output int lat);
        int n;
        bit found;
        req_addr  = a;
        req_we    = we;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rd = 32'd0;
        er = 1'b0;
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                found = 1'b1;
                rd = resp_rdata;
                er = resp_err;
            end
        end
        if (!found) lat = -1;
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("idle_rdata_zero", resp_rdata, 32'd0);
        chk("idle_err_zero", 32'(resp_err), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          saw;

        checks = 0;
        errors = 0;
        reset = 1'b1;
        req_valid = 1'b0; req_addr = 32'd0; req_we = 1'b0; req_wdata = 32'd0; req_be = 4'd0;
        req_valid_3 = 1'b0; req_addr_3 = 32'd0; req_we_3 = 1'b0; req_wdata_3 = 32'd0; req_be_3 = 4'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // Full-word write then read back
        access(32'h10, 1'b1, 32'hDEAD_BEEF, 4'b1111, rd, er, lat);
        chk("wr10_err", 32'(er), 32'd0);
        chk("wr10_latency", 32'(lat), 32'd2);
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
        access(32'h10, 1'b0, 32'h0, 4'b0000, rd, er, lat);
        chk("rd10_data", rd, 32'hDEAD_BEEF);
        chk("rd10_err", 32'(er), 32'd0);
        chk("rd10_latency", 32'(lat), 32'd2);

        // Partial byte-lane write
        access(32'h10, 1'b1, 32'h1122_3344, 4'b0101, rd, er, lat);
        chk("wr10_be0101_err", 32'(er), 32'd0);
        access(32'h10, 1'b0, 32'h0, 4'b1111, rd, er, lat);
        chk("rd10_merged", rd, 32'hDE22_BE44);

        // be = 0000 write is a no-op
        access(32'h10, 1'b1, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
        chk("wr_be0_err", 32'(er), 32'd0);
        access(32'h10, 1'b0, 32'h0, 4'b0000, rd, er, lat);
        chk("rd10_after_be0", rd, 32'hDE22_BE44);

        // Faults: misaligned read, out-of-range write
        access(32'h13, 1'b0, 32'h0, 4'b1111, rd, er, lat);
        chk("rd13_err", 32'(er), 32'd1);
        chk("rd13_rdata", rd, 32'd0);
        access(32'h400, 1'b1, 32'h5555_5555, 4'b1111, rd, er, lat);
        chk("wr400_err", 32'(er), 32'd1);
        chk("wr400_rdata", rd, 32'd0);
        access(32'h0, 1'b0, 32'h0, 4'b1111, rd, er, lat);
        chk("rd0_no_alias_err", 32'(er), 32'd0);
        access(32'h10, 1'b0, 32'h0, 4'b1111, rd, er, lat);
        chk("rd10_after_faults", rd, 32'hDE22_BE44);

        // Last valid word
        access(32'h3FC, 1'b1, 32'hCAFE_F00D, 4'b1111, rd, er, lat);
        chk("wr3fc_err", 32'(er), 32'd0);
        access(32'h3FC, 1'b0, 32'h0, 4'b0000, rd, er, lat);
        chk("rd3fc_data", rd, 32'hCAFE_F00D);
        chk("rd3fc_err", 32'(er), 32'd0);

        // Reset during WAIT of a write drops the write and the response
        access(32'h20, 1'b1, 32'h1234_5678, 4'b1111, rd, er, lat);
        chk("wr20_err", 32'(er), 32'd0);
        req_addr = 32'h20; req_we = 1'b1; req_wdata = 32'hAAAA_AAAA; req_be = 4'b1111;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) saw = 1'b1;
        end
        chk("midrst_no_response", 32'(saw), 32'd0);
        access(32'h20, 1'b0, 32'h0, 4'b1111, rd, er, lat);
        chk("rd20_old_value", rd, 32'h1234_5678);
        access(32'h10, 1'b0, 32'h0, 4'b1111, rd, er, lat);
        chk("rd10_survives_reset", rd, 32'hDE22_BE44);

`ifdef DMEM_RESP_MMIO_EN
        access(32'hFFFF_FFF0, 1'b1, 32'h0000_0041, 4'b0001, rd, er, lat);
        chk("con_wr41_err", 32'(er), 32'd0);
        access(32'hFFFF_FFF0, 1'b1, 32'h0000_0042, 4'b0001, rd, er, lat);
        chk("con_wr42_err", 32'(er), 32'd0);
        chk("con_strobe_count", 32'(strobe_cnt), 32'd2);
        chk("con_data", 32'(con_data), 32'h42);
        access(32'hFFFF_FFF0, 1'b0, 32'h0, 4'b0000, rd, er, lat);
        chk("con_rd_count", rd, 32'd2);
        chk("con_rd_err", 32'(er), 32'd0);
`else
        access(32'hFFFF_FFF0, 1'b0, 32'h0, 4'b1111, rd, er, lat);
        chk("con_rd_err", 32'(er), 32'd1);
        chk("con_rd_rdata", rd, 32'd0);
        access(32'hFFFF_FFF0, 1'b1, 32'h41, 4'b0001, rd, er, lat);
        chk("con_wr_err", 32'(er), 32'd1);
`endif

        // WAIT_CYCLES = 3 timing: RESP in cycle N+4, ready low N+1..N+4
        chk("w3_ready_before", 32'(req_ready_3), 32'd1);
        req_addr_3 = 32'h8; req_we_3 = 1'b1; req_wdata_3 = 32'h0BAD_F00D; req_be_3 = 4'b1111;
        req_valid_3 = 1'b1;
        @(posedge clk);
        #1;
        req_valid_3 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("w3_resp_valid_c%0d", k), 32'(resp_valid_3), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("w3_req_ready_c%0d", k), 32'(req_ready_3), (k >= 5) ? 32'd1 : 32'd0);
            if (k == 4) chk("w3_err", 32'(resp_err_3), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, memory capacity in bytes (multiple of 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra cycles between request accept and response (0..15).
REQ-003 SHALL have port clk input 1: the single clock; all state on rising edge.
REQ-004 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid input 1: core presents a request.
REQ-006 SHALL have port req_ready output 1: responder can accept a request this cycle.
REQ-007 SHALL have port req_addr input 32: byte address.
REQ-008 SHALL have port req_we input 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_wdata input 32: write data.
REQ-010 SHALL have port req_be input 4: byte enables, bit i = byte lane i.
REQ-011 SHALL have port resp_valid output 1: one-cycle response strobe.
REQ-012 SHALL have port resp_rdata output 32: read data, valid with resp_valid.
REQ-013 SHALL have port resp_err output 1: access fault, valid with resp_valid.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT is skipped when WAIT_CYCLES = 0.
REQ-015 SHALL drive req_ready = 1 only in IDLE with reset low.
REQ-016 SHALL accept a request on a rising edge with req_valid && req_ready, capturing addr/we/wdata/be.
REQ-017 SHALL ignore all request inputs outside IDLE; the core holds req_valid until accepted.
REQ-018 SHALL count WAIT_CYCLES cycles in WAIT with a 4-bit down-counter, then enter RESP.
REQ-019 SHALL assert resp_valid exactly one cycle, in RESP; accept at edge N gives resp_valid in cycle N+1+WAIT_CYCLES.
REQ-020 SHALL not support response back-pressure; the response is dropped if the core does not sample it.
REQ-021 SHALL flag a fault when addr[1:0] != 0 or addr >= MEM_SIZE: resp_err = 1, resp_rdata = 0, no memory change.
REQ-022 SHALL perform the write on the edge entering RESP, updating only lanes with req_be bit = 1; be = 4'b0000 is a legal no-op.
REQ-023 SHALL return the full word at addr[31:2] for reads, ignoring req_be, with resp_err = 0.
REQ-024 SHALL drive resp_rdata = 0 and resp_err = 0 whenever resp_valid = 0.
REQ-025 SHALL allow a new request to be accepted in the IDLE cycle right after RESP (back-to-back throughput: one access per 2+WAIT_CYCLES cycles).
REQ-026 SHALL show a read immediately following a write to the same word the written data.

Reset
REQ-027 SHALL on reset force FSM to IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 0 while reset is high.
REQ-028 SHALL discard an in-flight request on reset mid-operation; a write not yet committed SHALL NOT reach memory.
REQ-029 SHALL leave memory contents unchanged by reset.

Configuration
REQ-030 SHALL, with DMEM_RESP_MMIO_EN defined, add output con_data (8) and output con_strobe (1), both reset to 0, and map word 0xFFFF_FFF0 as a console register.
REQ-031 SHALL, with the macro, on a write to 0xFFFF_FFF0 with req_be[0] = 1, load req_wdata[7:0] into con_data and pulse con_strobe for the RESP cycle; a read returns a 32-bit count of such writes (wrapping).
REQ-032 SHALL, without the macro, have no extra ports and treat 0xFFFF_FFF0 as out of range (resp_err = 1).

Verification
REQ-033 SHALL cover: reset, then write 0x0000_0010 = 0xDEADBEEF be = 1111, then read it -> resp_rdata = 0xDEADBEEF, resp_err = 0.
REQ-034 SHALL cover: over word 0xDEADBEEF, write 0x0000_0010 data 0x11223344 be = 0101 -> read returns 0xDE22BE44.
REQ-035 SHALL cover: read 0x0000_0013, then write 0x0000_0400 (MEM_SIZE = 1024) -> resp_err = 1, rdata 0, memory unchanged.
REQ-036 SHALL cover: WAIT_CYCLES = 3, accept at edge N -> resp_valid only in cycle N+4, req_ready low in cycles N+1..N+4.
REQ-037 SHALL cover: reset pulsed during WAIT of a write to 0x20 -> no response, later read of 0x20 returns the old value.
REQ-038 SHALL cover: with DMEM_RESP_MMIO_EN, two writes 0x41, 0x42 to 0xFFFF_FFF0 -> con_strobe pulses twice, con_data = 0x42, read returns 2.
